// File: rtl/spi_ram_pkg.sv
// Shared types for the SPI RAM back-end: command tags and control FSM states.
package spi_ram_pkg;

  typedef enum logic [1:0] {
    CMD_WADDR = 2'b00,
    CMD_WDATA = 2'b01,
    CMD_RADDR = 2'b10,
    CMD_RDATA = 2'b11
  } spi_ram_cmd_e;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } spi_ram_state_e;

endpackage

// File: rtl/spi_ram_burst_core.sv
// Single-port synchronous RAM array with registered read data; contents are never reset.
module spi_ram_core
  import spi_ram_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int MEM_DEPTH = 256
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [MEM_DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Read-before-write on the same edge; a write is visible to a read one edge later.
  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
    rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/spi_ram_burst.sv
// SPI slave RAM back-end: tagged command decode, tx handshake, range check.
// Define SPI_RAM_AUTO_INC_EN to post-increment both pointers (with wrap) on data commands.
module spi_ram_burst
  import spi_ram_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int MEM_DEPTH = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic [DATA_W+1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              err
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);
  localparam logic [DATA_W:0]   DEPTH_EXT = (DATA_W + 1)'(MEM_DEPTH);

  spi_ram_state_e    state_q, state_d;
  logic [ADDR_W-1:0] addr_wr_q, addr_wr_d;
  logic [ADDR_W-1:0] addr_rd_q, addr_rd_d;
  logic [ADDR_W-1:0] rd_hold_q, rd_hold_d;
  logic              err_q, err_d;

  spi_ram_cmd_e      cmd;
  logic [DATA_W-1:0] payload;
  logic              accept;
  logic              addr_ok;
  logic              core_we;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_rdata;

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
`ifdef SPI_RAM_AUTO_INC_EN
    return (a == LAST_ADDR) ? '0 : a + 1'b1;
`else
    return a;
`endif
  endfunction

  assign cmd      = spi_ram_cmd_e'(din[DATA_W+1:DATA_W]);
  assign payload  = din[DATA_W-1:0];
  assign tx_valid = (state_q == HOLD);
  assign rx_ready = !tx_valid;
  assign accept   = rx_valid && rx_ready;
  // Full-width compare also rejects any payload bits set above ADDR_W.
  assign addr_ok  = ({1'b0, payload} < DEPTH_EXT);

  always_comb begin
    state_d   = state_q;
    addr_wr_d = addr_wr_q;
    addr_rd_d = addr_rd_q;
    rd_hold_d = rd_hold_q;
    err_d     = 1'b0;
    core_we   = 1'b0;
    core_addr = addr_rd_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          case (cmd)
            CMD_WADDR: begin
              if (addr_ok) addr_wr_d = payload[ADDR_W-1:0];
              else         err_d     = 1'b1;
            end
            CMD_WDATA: begin
              core_we   = 1'b1;
              core_addr = addr_wr_q;
              addr_wr_d = next_addr(addr_wr_q);
            end
            CMD_RADDR: begin
              if (addr_ok) addr_rd_d = payload[ADDR_W-1:0];
              else         err_d     = 1'b1;
            end
            CMD_RDATA: begin
              core_addr = addr_rd_q;
              rd_hold_d = addr_rd_q;
              addr_rd_d = next_addr(addr_rd_q);
              state_d   = HOLD;
            end
            default: ;
          endcase
        end
      end
      HOLD: begin
        // Keep re-reading the pending location so dout stays frozen until handoff.
        core_addr = rd_hold_q;
        if (tx_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_wr_q <= '0;
      addr_rd_q <= '0;
      rd_hold_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_wr_q <= addr_wr_d;
      addr_rd_q <= addr_rd_d;
      rd_hold_q <= rd_hold_d;
      err_q     <= err_d;
    end
  end

  spi_ram_core #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .MEM_DEPTH(MEM_DEPTH)
  ) u_core (
    .clk  (clk),
    .we   (core_we),
    .addr (core_addr),
    .wdata(payload),
    .rdata(core_rdata)
  );

  // Gating with tx_valid gives an immediate zero on async reset despite the unreset array.
  assign dout = tx_valid ? core_rdata : '0;
  assign err  = err_q;

endmodule
